bus_generator_n_arbiter: RTL and testbench
==========================================

Name: bus_generator_n_arbiter

Overview:
Shared-bus generator and round-robin arbiter connecting `drvrs` devices on each of `bits` independent buses. Each device exposes a pending FIFO head: `pndng`, with data on `D_pop`. The block pops one packet from the granted device, decodes its destination ID from the packet MSBs, and pushes the packet to the destination device(s) over `D_push`/`push`. It sits between the per-device driver FIFOs and the device receive FIFOs in the bus subsystem.

Parameters:
- bits, 1, number of independent buses, each with its own arbiter.
- drvrs, 4, number of devices per bus.
- pckg_sz, 16, packet width in bits; [pckg_sz-1:pckg_sz-8] is the destination ID, the rest is payload; must be >= 9.
- broadcast, 8'hFF, destination ID meaning "all devices".

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- pndng  input  [bits-1:0][drvrs-1:0]  device has a packet waiting.
- D_pop  input  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  head packet of each device; valid while its pndng=1.
- pop  output  [bits-1:0][drvrs-1:0]  one-cycle pulse consuming the head of the granted device.
- push  output  [bits-1:0][drvrs-1:0]  one-cycle pulse writing D_push into the destination device.
- D_push  output  [bits-1:0][drvrs-1:0][pckg_sz-1:0]  delivered packet, driven identically to all devices of a bus.

Behaviour:
- Reset (reset=0 at a clk edge): pop=0, push=0, D_push=0, FSM=IDLE, RR pointer last=drvrs-1 so device 0 has first priority. Reset mid-transfer abandons the transfer; a packet already popped is lost.
- Each bus runs an independent 3-state FSM: IDLE -> POP -> PUSH -> IDLE. All outputs are registered.
- IDLE: if any pndng bit on that bus is 1, grant the first set bit searching last+1, last+2, ... with wrap-around. Register the grant, set last=grant, go to POP. If no pndng bit is set, stay in IDLE.
- POP: pop[grant]=1 for exactly this cycle. At the closing edge, capture D_pop[grant] into pkt and record src=grant; go to PUSH.
- PUSH: D_push[all]=pkt, held until the next capture. Let id=pkt[pckg_sz-1 -: 8]:
  - id < drvrs: push[id]=1 for one cycle, including id==src (loopback allowed).
  - id == broadcast: see Optional Feature.
  - Any other id: packet dropped, no push.
  - Next state is IDLE.
- Latency: pndng rising in cycle N gives pop in N+1 and push in N+2. Peak throughput is one packet per 3 cycles per bus.
- pndng that drops before POP has no effect on the committed grant; pop is still issued (the device must tolerate it).
- Buses never interact; simultaneous activity on different buses is fully parallel.

Optional Feature:
- Macro: BUS_BROADCAST_EN.
- Defined: id==broadcast pushes to every device on the bus except src, in the same PUSH cycle.
- Undefined: id==broadcast is treated as invalid and the packet is dropped (no push).

Decomposition:
- Package bus_gnrtr_pkg holds:
  - the ID_W=8 constant;
  - the state enum {IDLE, POP, PUSH};
  - a function extracting the ID from a packet.
- Sub-module bus_rr_arbiter (one per bus, generate loop) contains the FSM, RR pointer, packet register and push decode. The top level only fans buses in and out.

Test Plan (drvrs=4, pckg_sz=16, bits=1):
- Reset held 0 for 3 cycles with pndng=4'b1111 -> pop, push and D_push all stay 0; after release, device 0 is granted first.
- Single write: device 1 pndng with D_pop=16'h0202 -> pop[1] pulses at N+1, push[2] pulses at N+2 with D_push=16'h0202.
- Contention: devices 0 and 1 both pending (0x0203 and 0x0202) with last=0 -> device 1 is served first, then device 0; each push goes to device 2 with correct data.
- Round-robin fairness: all 4 devices continuously pending -> grant order 0,1,2,3,0 with pops spaced 3 cycles apart.
- Invalid ID 16'h0555 from device 3 -> pop[3] pulses and no push occurs. Broadcast 16'hFF11 from device 0 -> push=4'b1110 with BUS_BROADCAST_EN defined, push=0 without it.
- Reset asserted during PUSH -> push is forced to 0 on the next edge and the FSM returns to IDLE.

Source files
------------

// File: rtl/bus_gnrtr_pkg.sv
// bus_gnrtr_pkg: shared ID width, arbiter FSM states and packet destination-ID extraction
// No ports. Compile-time option BUS_BROADCAST_EN is consumed by bus_rr_arbiter.
package bus_gnrtr_pkg;
  localparam int ID_W = 8;
  localparam int PKT_MAX = 1024;
  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;
  // Destination ID sits in the top ID_W bits of a pckg_sz-wide packet, zero-extended into PKT_MAX.
  function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX-1:0] pkt, input int sz);
    return ID_W'(pkt >> (sz - ID_W));
  endfunction
endpackage

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: one bus, round-robin pop from a pending device then push to the decoded destination
// Ports: clk; reset (sync, active-low); pndng/d_pop per-device FIFO heads; pop consume pulse;
// push delivery pulse; d_push delivered packet replicated to every device.
// Macro BUS_BROADCAST_EN: when defined, ID == broadcast pushes to every device except the source.
module bus_rr_arbiter import bus_gnrtr_pkg::*; #(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [drvrs-1:0]                pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   d_pop,
  output logic [drvrs-1:0]                pop,
  output logic [drvrs-1:0]                push,
  output logic [drvrs-1:0][pckg_sz-1:0]   d_push
);
  localparam int GW = drvrs > 1 ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] ONE = drvrs'(1);
  state_t state, state_nxt;
  logic [GW-1:0] last, last_nxt, pick;
  logic [pckg_sz-1:0] pkt, pkt_nxt;
  logic [drvrs-1:0] pop_nxt, push_nxt;
  logic [ID_W-1:0] id;
  logic hit;
  // last doubles as the committed grant while a transfer is in flight.
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      last  <= GW'(drvrs - 1);
      pkt   <= '0;
      pop   <= '0;
      push  <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      pkt   <= pkt_nxt;
      pop   <= pop_nxt;
      push  <= push_nxt;
    end
  always_comb begin
    hit = 1'b0;
    pick = last;
    state_nxt = state;
    last_nxt = last;
    pkt_nxt = pkt;
    pop_nxt = '0;
    push_nxt = '0;
    for (int i = 1; i <= drvrs; i++)
      if (!hit && pndng[GW'((int'(last) + i) % drvrs)]) begin
        hit = 1'b1;
        pick = GW'((int'(last) + i) % drvrs);
      end
    id = pkt_id(PKT_MAX'(d_pop[last]), pckg_sz);
    if (state == IDLE && hit) begin
      state_nxt = POP;
      last_nxt = pick;
      pop_nxt = ONE << pick;
    end else if (state == POP) begin
      state_nxt = PUSH;
      pkt_nxt = d_pop[last];
      // IDs at or beyond drvrs shift the single bit out, which drops the packet.
`ifdef BUS_BROADCAST_EN
      push_nxt = (id == broadcast) ? ~(ONE << last) : ONE << id;
`else
      push_nxt = (id == broadcast) ? '0 : ONE << id;
`endif
    end else if (state == PUSH)
      state_nxt = IDLE;
  end
  assign d_push = {drvrs{pkt}};
endmodule

// File: rtl/bus_generator_n_arbiter.sv
// bus_generator_n_arbiter: bits independent buses, each with its own round-robin arbiter
// Ports: clk; reset (sync, active-low); pndng/D_pop per-bus per-device FIFO heads;
// pop/push per-bus per-device pulses; D_push per-bus packet replicated to all devices.
// Macro BUS_BROADCAST_EN enables broadcast delivery inside each bus_rr_arbiter.
module bus_generator_n_arbiter import bus_gnrtr_pkg::*; #(
  parameter int bits = 1,
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [bits-1:0][drvrs-1:0]                pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_pop,
  output logic [bits-1:0][drvrs-1:0]                pop,
  output logic [bits-1:0][drvrs-1:0]                push,
  output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]   D_push
);
  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_rr_arbiter #(.drvrs(drvrs), .pckg_sz(pckg_sz), .broadcast(broadcast)) u_arb (
      .clk(clk),
      .reset(reset),
      .pndng(pndng[b]),
      .d_pop(D_pop[b]),
      .pop(pop[b]),
      .push(push[b]),
      .d_push(D_push[b])
    );
  end
endmodule

// File: tb/tb_bus_generator_n_arbiter.sv
// tb_bus_generator_n_arbiter: directed and randomized checks of the bus generator against a transaction model
module tb_bus_generator_n_arbiter;
  localparam int BITS = 2, DRV = 4, PW = 16, BW = 1, DW = 2;
`ifdef BUS_BROADCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [BITS-1:0][DRV-1:0] pndng = '0;
  logic [BITS-1:0][DRV-1:0][PW-1:0] D_pop = '0;
  logic [BITS-1:0][DRV-1:0] pop, push;
  logic [BITS-1:0][DRV-1:0][PW-1:0] D_push;
  int checks = 0, errors = 0, cyc = 0;
  logic [BITS-1:0][DRV-1:0] m_pop, m_push;
  logic [BITS-1:0][PW-1:0] m_pkt;
  int m_last[BITS], m_free[BITS], m_cap[BITS];
  bus_generator_n_arbiter #(.bits(BITS), .drvrs(DRV), .pckg_sz(PW), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  // Transaction model: a bus accepts a new grant at most every 3 edges; the packet is taken one edge after the grant.
  task automatic model_step();
    for (int b = 0; b < BITS; b++) begin
      logic [BW-1:0] x;
      int id, g;
      x = BW'(b);
      m_pop[x] = '0;
      m_push[x] = '0;
      if (!reset) begin
        m_last[x] = DRV - 1;
        m_cap[x] = -1;
        m_free[x] = 0;
        m_pkt[x] = '0;
      end else if (m_cap[x] >= 0) begin
        m_pkt[x] = D_pop[x][DW'(m_cap[x])];
        id = int'(m_pkt[x][PW-1 -: 8]);
        if (id < DRV) m_push[x][DW'(id)] = 1'b1;
        else if (BC && id == 255) m_push[x] = ~(DRV'(1) << m_cap[x]);
        m_cap[x] = -1;
      end else if (cyc >= m_free[x] && pndng[x] != '0) begin
        g = -1;
        for (int j = 1; j <= DRV; j++)
          if (g < 0 && pndng[x][DW'((m_last[x] + j) % DRV)]) g = (m_last[x] + j) % DRV;
        m_last[x] = g;
        m_pop[x][DW'(g)] = 1'b1;
        m_cap[x] = g;
        m_free[x] = cyc + 3;
      end
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic test_reset();
    reset = 1'b0;
    pndng[0] = 4'hF;
    for (int d = 0; d < DRV; d++) D_pop[0][DW'(d)] = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (pop !== '0 || push !== '0 || D_push !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: pop=%h push=%h D_push=%h, required all zero", i, pop, push, D_push);
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (pop !== 8'h01) begin
      errors++;
      $display("FAIL reset_first_grant: pop=%h, required 01", pop);
    end
    pndng[0] = '0;
    tick();
    tick();
  endtask
  task automatic test_single();
    pndng[0] = 4'b0010;
    D_pop[0][1] = 16'h0202;
    tick();
    checks++;
    if (pop !== 8'h02 || push !== '0) begin
      errors++;
      $display("FAIL single_pop: pop=%h push=%h, required 02/00", pop, push);
    end
    pndng[0] = '0;
    tick();
    checks++;
    if (push !== 8'h04 || pop !== '0 || D_push !== {64'h0, {4{16'h0202}}}) begin
      errors++;
      $display("FAIL single_push: push=%h pop=%h D_push=%h, required 04/00/0202x4", push, pop, D_push);
    end
    tick();
    checks++;
    if (push !== '0 || D_push !== {64'h0, {4{16'h0202}}}) begin
      errors++;
      $display("FAIL single_hold: push=%h D_push=%h, required 00 and data held", push, D_push);
    end
  endtask
  task automatic test_contention();
    pndng[0] = 4'b0001;
    D_pop[0][0] = 16'h0203;
    tick();
    pndng[0] = '0;
    tick();
    tick();
    pndng[0] = 4'b0011;
    D_pop[0][1] = 16'h0202;
    tick();
    checks++;
    if (pop !== 8'h02) begin
      errors++;
      $display("FAIL contention_first: pop=%h, required 02", pop);
    end
    pndng[0] = 4'b0001;
    tick();
    checks++;
    if (push !== 8'h04 || D_push[0][2] !== 16'h0202) begin
      errors++;
      $display("FAIL contention_push1: push=%h data=%h, required 04/0202", push, D_push[0][2]);
    end
    tick();
    checks++;
    if (pop !== '0) begin
      errors++;
      $display("FAIL contention_gap: pop=%h, required 00", pop);
    end
    tick();
    checks++;
    if (pop !== 8'h01) begin
      errors++;
      $display("FAIL contention_second: pop=%h, required 01", pop);
    end
    pndng[0] = '0;
    tick();
    checks++;
    if (push !== 8'h04 || D_push[0][2] !== 16'h0203) begin
      errors++;
      $display("FAIL contention_push2: push=%h data=%h, required 04/0203", push, D_push[0][2]);
    end
    tick();
  endtask
  task automatic test_rr_fair();
    logic [15:0] e;
    reset = 1'b0;
    pndng[0] = 4'hF;
    for (int j = 0; j < DRV; j++) D_pop[0][DW'(j)] = {8'((j + 1) % DRV), 8'(160 + j)};
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      int g;
      g = i % DRV;
      e = {8'((g + 1) % DRV), 8'(160 + g)};
      tick();
      checks++;
      if (pop !== 8'(1) << g) begin
        errors++;
        $display("FAIL rr_grant%0d: pop=%h, required %h", i, pop, 8'(1) << g);
      end
      tick();
      checks++;
      if (push !== 8'(1) << ((g + 1) % DRV) || pop !== '0 || D_push[0][0] !== e) begin
        errors++;
        $display("FAIL rr_push%0d: push=%h pop=%h data=%h, required %h/00/%h", i, push, pop, D_push[0][0], 8'(1) << ((g + 1) % DRV), e);
      end
      tick();
      checks++;
      if (pop !== '0 || push !== '0) begin
        errors++;
        $display("FAIL rr_idle%0d: pop=%h push=%h, required 00/00", i, pop, push);
      end
    end
    pndng[0] = '0;
  endtask
  task automatic test_invalid_broadcast();
    pndng[0] = 4'b1000;
    D_pop[0][3] = 16'h0555;
    tick();
    checks++;
    if (pop !== 8'h08) begin
      errors++;
      $display("FAIL invalid_pop: pop=%h, required 08", pop);
    end
    pndng[0] = '0;
    tick();
    checks++;
    if (push !== '0 || D_push[0][0] !== 16'h0555) begin
      errors++;
      $display("FAIL invalid_drop: push=%h data=%h, required 00/0555", push, D_push[0][0]);
    end
    tick();
    pndng[0] = 4'b0001;
    D_pop[0][0] = 16'hFF11;
    tick();
    pndng[0] = '0;
    tick();
    checks++;
    if (push !== (BC ? 8'h0E : 8'h00) || D_push[0][3] !== 16'hFF11) begin
      errors++;
      $display("FAIL broadcast: push=%h data=%h, required %h/FF11", push, D_push[0][3], BC ? 8'h0E : 8'h00);
    end
    tick();
  endtask
  task automatic test_reset_mid();
    pndng[0] = 4'b0100;
    D_pop[0][2] = 16'h0101;
    tick();
    pndng[0] = '0;
    tick();
    checks++;
    if (push !== 8'h02) begin
      errors++;
      $display("FAIL midreset_prepush: push=%h, required 02", push);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (push !== '0 || pop !== '0 || D_push !== '0) begin
      errors++;
      $display("FAIL midreset_clear: push=%h pop=%h D_push=%h, required zeros", push, pop, D_push);
    end
    reset = 1'b1;
    pndng[0] = 4'b0100;
    tick();
    checks++;
    if (pop !== 8'h04) begin
      errors++;
      $display("FAIL midreset_idle: pop=%h, required 04", pop);
    end
    pndng[0] = '0;
    tick();
    tick();
  endtask
  task automatic test_random();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int n = 0; n < 400; n++) begin
      reset = $urandom_range(0, 63) != 0;
      for (int b = 0; b < BITS; b++) begin
        pndng[BW'(b)] = DRV'($urandom_range(0, 3) == 0 ? 0 : $urandom);
        for (int d = 0; d < DRV; d++) begin
          int r;
          r = $urandom_range(0, 5);
          D_pop[BW'(b)][DW'(d)] = {r < 4 ? 8'(r) : (r == 4 ? 8'hFF : 8'($urandom)), 8'($urandom)};
        end
      end
      tick();
      for (int b = 0; b < BITS; b++) begin
        logic [BW-1:0] x;
        x = BW'(b);
        checks++;
        if (pop[x] !== m_pop[x] || push[x] !== m_push[x] || D_push[x] !== {DRV{m_pkt[x]}}) begin
          errors++;
          $display("FAIL random n%0d bus%0d: pop=%h push=%h data=%h, required %h/%h/%h", n, b, pop[x], push[x], D_push[x][0], m_pop[x], m_push[x], m_pkt[x]);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_rr_fair();
    test_invalid_broadcast();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
